// File: rtl/rgb_fx_pkg.sv
// Shared types and constants for the RGB effect sequencer and its neighbours.
package rgb_fx_pkg;

  // Default field widths of a program entry
  localparam int FX_MODE_W  = 4;
  localparam int FX_FRAME_W = 8;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } fx_state_t;

  // Effect mode codes understood by the RGB colour-effect stage
  localparam logic [FX_MODE_W-1:0] FX_NORMAL   = 4'd0;
  localparam logic [FX_MODE_W-1:0] FX_INVERT   = 4'd1;
  localparam logic [FX_MODE_W-1:0] FX_SWAP     = 4'd2;
  localparam logic [FX_MODE_W-1:0] FX_SWAP_INV = 4'd3;
  localparam logic [FX_MODE_W-1:0] FX_MASH1    = 4'd4;
  localparam logic [FX_MODE_W-1:0] FX_MASH2    = 4'd5;
  localparam logic [FX_MODE_W-1:0] FX_POST50   = 4'd7;
  localparam logic [FX_MODE_W-1:0] FX_POST70   = 4'd8;
  localparam logic [FX_MODE_W-1:0] FX_KEY_R    = 4'd9;
  localparam logic [FX_MODE_W-1:0] FX_KEY_G    = 4'd10;

  // One program entry at the default widths
  typedef struct packed {
    logic [FX_MODE_W-1:0]  mode;
    logic [FX_FRAME_W-1:0] frames;
  } fx_entry_t;

endpackage

// File: rtl/vsync_edge_det.sv
// Registered rising-edge detector for a pixel-clock-synchronous vsync level.
// The pulse appears one clock after the rising edge and lasts one clock,
// however long vsync stays high.
module vsync_edge_det (
  input  logic i_pxclk,
  input  logic i_rst,
  input  logic i_vsync,
  output logic o_tick
);

  logic r_vsync_d;
  logic r_tick;

  // Delay vsync by one clock and register the rising-edge pulse
  always_ff @(posedge i_pxclk or posedge i_rst) begin
    if (i_rst) begin
      r_vsync_d <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_vsync_d <= i_vsync;
      r_tick    <= i_vsync & ~r_vsync_d;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/rgb_fx_sequencer.sv
// Frame-locked sequencer that walks a small writable program of
// (mode, frames) entries and drives the effect-stage mode code. Every mode
// change, programmed or manual, lands on the clock after a frame tick.
module rgb_fx_sequencer
  import rgb_fx_pkg::*;
#(
  parameter int STEPS   = 8,
  parameter int FRAME_W = FX_FRAME_W,
  parameter int MODE_W  = FX_MODE_W,
  localparam int AW     = $clog2(STEPS)
) (
  input  logic               i_pxclk,
  input  logic               i_rst,
  input  logic               i_vsync,
  input  logic               i_enable,
  input  logic               i_manual_sel,
  input  logic [MODE_W-1:0]  i_manual_mode,
  input  logic               i_prog_we,
  input  logic [AW-1:0]      i_prog_addr,
  input  logic [MODE_W-1:0]  i_prog_mode,
  input  logic [FRAME_W-1:0] i_prog_frames,
  input  logic [AW-1:0]      i_prog_last,
  output logic [MODE_W-1:0]  o_mode,
  output logic [AW-1:0]      o_step,
  output logic               o_frame_tick,
  output logic               o_running
);

  // A stored duration of zero still runs for one frame
  function automatic logic [FRAME_W-1:0] exec_len(input logic [FRAME_W-1:0] f);
    logic [FRAME_W-1:0] len;
    if (f == {FRAME_W{1'b0}}) begin
      len = FRAME_W'(1);
    end else begin
      len = f;
    end
    return len;
  endfunction

  logic               w_tick;

  logic [MODE_W-1:0]  r_prog_mode   [STEPS];
  logic [FRAME_W-1:0] r_prog_frames [STEPS];

  fx_state_t          r_state;
  logic [AW-1:0]      r_step;
  logic [FRAME_W-1:0] r_cnt;
  logic [MODE_W-1:0]  r_mode;
  logic [MODE_W-1:0]  r_cur_mode;   // mode of the loaded entry, kept while manual overrides it
  logic               r_running;

  fx_state_t          w_state_nxt;
  logic [AW-1:0]      w_step_nxt;
  logic [FRAME_W-1:0] w_cnt_nxt;
  logic [MODE_W-1:0]  w_mode_nxt;
  logic [MODE_W-1:0]  w_cur_mode_nxt;
  logic               w_running_nxt;

  logic [AW-1:0]      w_next_idx;
  logic [MODE_W-1:0]  w_next_mode;
  logic [FRAME_W-1:0] w_next_len;
  logic [MODE_W-1:0]  w_first_mode;
  logic [FRAME_W-1:0] w_first_len;

  vsync_edge_det u_edge (
    .i_pxclk (i_pxclk),
    .i_rst   (i_rst),
    .i_vsync (i_vsync),
    .o_tick  (w_tick)
  );

  // Program storage: reset to {mode 0, 1 frame}, written one entry per clock.
  // Reads are combinational from the flops, so a load on the same clock as a
  // write to that entry sees the old contents.
  always_ff @(posedge i_pxclk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < STEPS; i++) begin
        r_prog_mode[i]   <= {MODE_W{1'b0}};
        r_prog_frames[i] <= FRAME_W'(1);
      end
    end else if (i_prog_we) begin
      r_prog_mode[i_prog_addr]   <= i_prog_mode;
      r_prog_frames[i_prog_addr] <= i_prog_frames;
    end else begin
      r_prog_mode   <= r_prog_mode;
      r_prog_frames <= r_prog_frames;
    end
  end

  // Next entry index and the contents of both candidate entries for loading
  always_comb begin
    w_next_idx = AW'(0);
    if (r_step >= i_prog_last) begin
      w_next_idx = AW'(0);
    end else begin
      w_next_idx = r_step + AW'(1);
    end
    w_next_mode  = r_prog_mode[w_next_idx];
    w_next_len   = exec_len(r_prog_frames[w_next_idx]);
    w_first_mode = r_prog_mode[AW'(0)];
    w_first_len  = exec_len(r_prog_frames[AW'(0)]);
  end

  // Sequencer next-state logic; dropping enable wins over a tick on the same clock
  always_comb begin
    w_state_nxt    = r_state;
    w_step_nxt     = r_step;
    w_cnt_nxt      = r_cnt;
    w_mode_nxt     = r_mode;
    w_cur_mode_nxt = r_cur_mode;
    w_running_nxt  = r_running;

    if (!i_enable) begin
      w_state_nxt   = ST_IDLE;
      w_step_nxt    = AW'(0);
      w_cnt_nxt     = {FRAME_W{1'b0}};
      w_running_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt   = ST_ARM;
          w_step_nxt    = AW'(0);
          w_cnt_nxt     = {FRAME_W{1'b0}};
          w_running_nxt = 1'b0;
          if (w_tick && i_manual_sel) begin
            w_mode_nxt = i_manual_mode;
          end else begin
            w_mode_nxt = r_mode;
          end
        end
        ST_ARM: begin
          if (w_tick) begin
            w_state_nxt    = ST_RUN;
            w_step_nxt     = AW'(0);
            w_cnt_nxt      = w_first_len;
            w_cur_mode_nxt = w_first_mode;
            w_running_nxt  = 1'b1;
            if (i_manual_sel) begin
              w_mode_nxt = i_manual_mode;
            end else begin
              w_mode_nxt = w_first_mode;
            end
          end else begin
            w_state_nxt = ST_ARM;
          end
        end
        ST_RUN: begin
          if (w_tick) begin
            if (r_cnt > FRAME_W'(1)) begin
              w_cnt_nxt = r_cnt - FRAME_W'(1);
            end else begin
              w_step_nxt     = w_next_idx;
              w_cnt_nxt      = w_next_len;
              w_cur_mode_nxt = w_next_mode;
            end
            if (i_manual_sel) begin
              w_mode_nxt = i_manual_mode;
            end else begin
              w_mode_nxt = w_cur_mode_nxt;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_step_nxt    = AW'(0);
          w_cnt_nxt     = {FRAME_W{1'b0}};
          w_running_nxt = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and output registers
  always_ff @(posedge i_pxclk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_step     <= AW'(0);
      r_cnt      <= {FRAME_W{1'b0}};
      r_mode     <= {MODE_W{1'b0}};
      r_cur_mode <= {MODE_W{1'b0}};
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mode     <= w_mode_nxt;
      r_cur_mode <= w_cur_mode_nxt;
      r_running  <= w_running_nxt;
    end
  end

  assign o_mode       = r_mode;
  assign o_step       = r_step;
  assign o_frame_tick = w_tick;
  assign o_running    = r_running;

endmodule

// File: tb/tb_rgb_fx_sequencer.sv
// Self-checking bench for rgb_fx_sequencer: expected (mode, step, running)
// triples are queued when a vsync pulse is driven and checked when the
// sequencer updates two clocks after the vsync rise.
module tb_rgb_fx_sequencer;
  import rgb_fx_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync;
  logic       enable;
  logic       manual_sel;
  logic [3:0] manual_mode;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [3:0] prog_mode;
  logic [7:0] prog_frames;
  logic [2:0] prog_last;
  logic [3:0] mode;
  logic [2:0] step;
  logic       frame_tick;
  logic       running;

  int total = 0;
  int bad   = 0;

  logic [3:0] q_mode [$];
  logic [2:0] q_step [$];
  logic       q_run  [$];
  logic [3:0] cur_mode;

  // write scheduled to coincide with the tick clock of the next pulse
  logic       wr_pend = 1'b0;
  logic [2:0] wr_addr;
  logic [3:0] wr_mode;
  logic [7:0] wr_frames;
  logic       drop_en = 1'b0;

  rgb_fx_sequencer dut (
    .i_pxclk       (clk),
    .i_rst         (rst),
    .i_vsync       (vsync),
    .i_enable      (enable),
    .i_manual_sel  (manual_sel),
    .i_manual_mode (manual_mode),
    .i_prog_we     (prog_we),
    .i_prog_addr   (prog_addr),
    .i_prog_mode   (prog_mode),
    .i_prog_frames (prog_frames),
    .i_prog_last   (prog_last),
    .o_mode        (mode),
    .o_step        (step),
    .o_frame_tick  (frame_tick),
    .o_running     (running)
  );

  always #5 clk = ~clk;

  task automatic write_entry(input logic [2:0] a, input logic [3:0] m, input logic [7:0] f);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_mode = m; prog_frames = f;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // One vsync pulse; checks tick timing, mode hold before the update, then the queued result
  task automatic pulse(input logic [3:0] em, input logic [2:0] es, input logic er, input string nm);
    logic [3:0] xm;
    logic [2:0] xs;
    logic       xr;
    q_mode.push_back(em); q_step.push_back(es); q_run.push_back(er);
    @(negedge clk);
    vsync = 1'b1;
    @(posedge clk); #1;
    total++;
    if (frame_tick !== 1'b1) begin bad++; $display("FAIL %s_tick: got %b want 1", nm, frame_tick); end
    total++;
    if (mode !== cur_mode) begin bad++; $display("FAIL %s_early_mode: got %0d want %0d", nm, mode, cur_mode); end
    @(negedge clk);
    vsync = 1'b0;
    if (wr_pend) begin
      prog_we = 1'b1; prog_addr = wr_addr; prog_mode = wr_mode; prog_frames = wr_frames;
    end
    if (drop_en) enable = 1'b0;
    @(posedge clk); #1;
    xm = q_mode.pop_front(); xs = q_step.pop_front(); xr = q_run.pop_front();
    total++;
    if (mode !== xm) begin bad++; $display("FAIL %s_mode: got %0d want %0d", nm, mode, xm); end
    total++;
    if (step !== xs) begin bad++; $display("FAIL %s_step: got %0d want %0d", nm, step, xs); end
    total++;
    if (running !== xr) begin bad++; $display("FAIL %s_running: got %b want %b", nm, running, xr); end
    total++;
    if (frame_tick !== 1'b0) begin bad++; $display("FAIL %s_tick_len: got %b want 0", nm, frame_tick); end
    cur_mode = xm;
    @(negedge clk);
    prog_we = 1'b0; wr_pend = 1'b0; drop_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; vsync = 1'b0; enable = 1'b0; manual_sel = 1'b0; manual_mode = 4'd0;
    prog_we = 1'b0; prog_addr = 3'd0; prog_mode = 4'd0; prog_frames = 8'd0; prog_last = 3'd0;
    #1;
    total++;
    if ({mode, step, frame_tick, running} !== 9'd0) begin
      bad++; $display("FAIL reset_outputs: got m=%0d s=%0d t=%b r=%b want all 0", mode, step, frame_tick, running);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur_mode = 4'd0;
  endtask

  task automatic test_program;
    logic [3:0] em [10] = '{4'd1, 4'd1, 4'd4, 4'd8, 4'd8, 4'd8, 4'd1, 4'd1, 4'd4, 4'd8};
    logic [2:0] es [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd1, 3'd2};
    write_entry(3'd0, FX_INVERT, 8'd2);
    write_entry(3'd1, FX_MASH1, 8'd1);
    write_entry(3'd2, FX_POST70, 8'd3);
    @(negedge clk);
    prog_last = 3'd2; enable = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (running !== 1'b0) begin bad++; $display("FAIL arm_running: got %b want 0", running); end
    for (int i = 0; i < 10; i++) pulse(em[i], es[i], 1'b1, "program");
  endtask

  task automatic test_vsync_held;
    int ticks = 0;
    @(negedge clk);
    vsync = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (frame_tick === 1'b1) ticks++;
    end
    total++;
    if (ticks !== 1) begin bad++; $display("FAIL held_ticks: got %0d want 1", ticks); end
    total++;
    if (mode !== 4'd8 || step !== 3'd2) begin bad++; $display("FAIL held_state: got m=%0d s=%0d want m=8 s=2", mode, step); end
    @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    pulse(4'd8, 3'd2, 1'b1, "held_after1");
    pulse(4'd1, 3'd0, 1'b1, "held_after2");
  endtask

  task automatic test_manual;
    @(negedge clk);
    manual_sel = 1'b1; manual_mode = FX_SWAP;
    repeat (3) @(negedge clk);
    total++;
    if (mode !== 4'd1) begin bad++; $display("FAIL manual_midframe: got %0d want 1", mode); end
    pulse(4'd2, 3'd0, 1'b1, "manual1");
    pulse(4'd2, 3'd1, 1'b1, "manual2");
    @(negedge clk);
    manual_sel = 1'b0;
    pulse(4'd8, 3'd2, 1'b1, "manual_resume");
  endtask

  task automatic test_prog_write;
    pulse(4'd8, 3'd2, 1'b1, "wr_a"); pulse(4'd8, 3'd2, 1'b1, "wr_b");
    pulse(4'd1, 3'd0, 1'b1, "wr_c"); pulse(4'd1, 3'd0, 1'b1, "wr_d");
    pulse(4'd4, 3'd1, 1'b1, "wr_e");
    write_entry(3'd1, FX_POST50, 8'd5);
    repeat (2) @(negedge clk);
    total++;
    if (mode !== 4'd4 || step !== 3'd1) begin bad++; $display("FAIL wr_executing: got m=%0d s=%0d want m=4 s=1", mode, step); end
    pulse(4'd8, 3'd2, 1'b1, "wr_f"); pulse(4'd8, 3'd2, 1'b1, "wr_g"); pulse(4'd8, 3'd2, 1'b1, "wr_h");
    pulse(4'd1, 3'd0, 1'b1, "wr_i"); pulse(4'd1, 3'd0, 1'b1, "wr_j");
    pulse(4'd7, 3'd1, 1'b1, "wr_new");
    for (int i = 0; i < 4; i++) pulse(4'd7, 3'd1, 1'b1, "wr_len5");
    wr_pend = 1'b1; wr_addr = 3'd2; wr_mode = FX_KEY_G; wr_frames = 8'd1;
    pulse(4'd8, 3'd2, 1'b1, "wr_same_clk");
    pulse(4'd8, 3'd2, 1'b1, "wr_old_len");
  endtask

  task automatic test_wrap_and_disable;
    @(negedge clk);
    prog_last = 3'd0;
    write_entry(3'd0, FX_MASH2, 8'd0);
    pulse(4'd8, 3'd2, 1'b1, "wrap_last");
    pulse(4'd5, 3'd0, 1'b1, "wrap_zero");
    pulse(4'd5, 3'd0, 1'b1, "wrap_repeat");
    drop_en = 1'b1;
    pulse(4'd5, 3'd0, 1'b0, "disable");
    pulse(4'd5, 3'd0, 1'b0, "idle_tick");
  endtask

  task automatic test_reset_mid_run;
    write_entry(3'd0, 4'd1, 8'd1);
    write_entry(3'd1, 4'd1, 8'd1);
    write_entry(3'd2, 4'd1, 8'd1);
    write_entry(3'd3, FX_MASH2, 8'd10);
    @(negedge clk);
    prog_last = 3'd3; enable = 1'b1;
    repeat (2) @(negedge clk);
    pulse(4'd1, 3'd0, 1'b1, "pre_rst0");
    pulse(4'd1, 3'd1, 1'b1, "pre_rst1");
    pulse(4'd1, 3'd2, 1'b1, "pre_rst2");
    pulse(4'd5, 3'd3, 1'b1, "pre_rst3");
    @(negedge clk);
    vsync = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++;
    if ({mode, step, frame_tick, running} !== 9'd0) begin
      bad++; $display("FAIL async_reset: got m=%0d s=%0d t=%b r=%b want all 0", mode, step, frame_tick, running);
    end
    @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; prog_last = 3'd1;
    cur_mode = 4'd0;
    repeat (2) @(negedge clk);
    pulse(4'd0, 3'd0, 1'b1, "post_rst0");
    pulse(4'd0, 3'd1, 1'b1, "post_rst1");
    pulse(4'd0, 3'd0, 1'b1, "post_rst2");
  endtask

  initial begin
    test_reset();
    test_program();
    test_vsync_held();
    test_manual();
    test_prog_write();
    test_wrap_and_disable();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
